stage_writeback: RTL and testbench
==================================

Name: stage_writeback

Overview:
- Final pipeline stage of the core.
- Consumes the modified cell value and opcode from the modify stage.
- Commits INC/DEC results to data RAM, drives OUT bytes to the output port, and fetches IN bytes from the input port and writes them to RAM.
- Back-pressures upstream through `ack` while an I/O transfer is pending.

Parameters:
- D_WIDTH, 8, cell/data width.
- A_WIDTH, 16, data-pointer / RAM address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- operation_in  in  `OPCODE_MSB+1`  one-hot opcode from modify stage (`OP_INC`, `OP_DEC`, `OP_IN`, `OP_OUT` bits).
- a_in  in  D_WIDTH  modified cell value from modify stage.
- dp_in  in  A_WIDTH  data pointer for this operation.
- drdy_in  in  1  upstream data valid.
- ack  out  1  stage can accept; transfer occurs when drdy_in && ack.
- mem_we  out  1  RAM write strobe, one cycle per write.
- mem_addr  out  A_WIDTH  RAM write address.
- mem_wdata  out  D_WIDTH  RAM write data.
- out_data  out  D_WIDTH  output byte.
- out_valid  out  1  output byte valid.
- out_ready  in  1  output sink ready.
- in_data  in  D_WIDTH  input byte.
- in_valid  in  1  input source valid.
- in_ready  out  1  stage requests input byte.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous assertion):
  - State goes to IDLE.
  - mem_we, mem_addr, mem_wdata, out_data, out_valid and in_ready are all 0.
  - The latched pointer is cleared.
  - Reset mid-transfer aborts it: no RAM write, the OUT byte is dropped and out_valid falls immediately.
- Combinational outputs:
  - ack = (state == IDLE).
  - busy = !ack.
- All other outputs are registered.
- mem_we defaults to 0 every cycle unless set below, so it is a single-cycle pulse.
- Opcode priority when more than one bit is set: INC > DEC > IN > OUT; no set bit means NOP.
- IDLE, when drdy_in && ack:
  - INC or DEC: next cycle mem_we=1, mem_addr=dp_in, mem_wdata=a_in; stay in IDLE. Back-to-back INC/DEC sustain one write per cycle.
  - OUT: out_data<=a_in, out_valid<=1; go to OUT_WAIT.
  - IN: latch dp_in, in_ready<=1; go to IN_WAIT.
  - NOP or other opcode: consumed, no side effect; stay in IDLE.
- IDLE with drdy_in=0: hold, no write.
- OUT_WAIT:
  - ack=0.
  - out_data and out_valid are held stable until out_valid && out_ready.
  - On that cycle: out_valid<=0; go to IDLE. The next upstream transfer can occur the cycle after.
- IN_WAIT:
  - ack=0; in_ready is held at 1.
  - On in_valid && in_ready: in_ready<=0; next cycle mem_we=1, mem_addr=latched pointer, mem_wdata=in_data; go to IDLE.
  - a_in is ignored for IN.
- Latency: RAM write appears 1 cycle after acceptance (INC/DEC) or 1 cycle after the input handshake (IN).
- No wrap logic in this stage. Arithmetic and pointer wrap are done upstream; address and data pass through unmodified, modulo their widths.
- In OUT_WAIT or IN_WAIT, drdy_in is ignored. Upstream must hold operation_in, a_in and dp_in until ack.
- Input or output arriving early: in_valid asserted while not in IN_WAIT is ignored, and in_data is not sampled. out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Reset then INC: a_in=0x05, dp_in=0x0010, drdy_in=1 for 1 cycle -> next cycle mem_we=1, mem_addr=0x0010, mem_wdata=0x05; mem_we=0 the following cycle; ack stays 1.
- Back-to-back DEC at dp 0x0001, 0x0002, 0x0003 with data 0xFF, 0x00, 0x7F -> three consecutive mem_we pulses with matching address/data; no bubbles.
- OUT a_in=0x41 with out_ready=0 for 4 cycles, then 1:
  - out_valid=1 and out_data=0x41 stable throughout; ack=0 and busy=1 for 5 cycles.
  - out_valid=0 and ack=1 after the handshake.
  - A DEC presented during the wait is not accepted and produces no mem_we.
- IN at dp 0x1234, in_valid raised 3 cycles later with in_data=0x7A -> in_ready=1 until the handshake; one cycle later mem_we=1, mem_addr=0x1234, mem_wdata=0x7A.
- Opcode with both INC and OUT bits set, a_in=0x09 -> treated as INC: RAM write of 0x09, out_valid stays 0.
- Assert reset=0 asynchronously mid-cycle during OUT_WAIT -> out_valid, in_ready and mem_we drop to 0 without a clock edge; after release state is IDLE and ack=1, with no RAM write.

Source files
------------

// File: rtl/stage_writeback.sv
// Writeback stage: commits INC/DEC/IN results to data RAM
// and drives OUT bytes, stalling upstream during I/O.
package stage_writeback_pkg;
  localparam int OPCODE_MSB = 3;
  localparam int OP_INC = 0;
  localparam int OP_DEC = 1;
  localparam int OP_OUT = 2;
  localparam int OP_IN  = 3;
endpackage

module stage_writeback
  import stage_writeback_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_MSB:0] operation_in,
  input  logic [D_WIDTH-1:0]  a_in,
  input  logic [A_WIDTH-1:0]  dp_in,
  input  logic                drdy_in,
  output logic                ack,
  output logic                mem_we,
  output logic [A_WIDTH-1:0]  mem_addr,
  output logic [D_WIDTH-1:0]  mem_wdata,
  output logic [D_WIDTH-1:0]  out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic [D_WIDTH-1:0]  in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    OUT_WAIT,
    IN_WAIT
  } state_t;

  state_t             state;
  logic [A_WIDTH-1:0] ptr;

  // Upstream may transfer only while no I/O is pending
  always_comb begin
    ack  = (state == IDLE);
    busy = !ack;
  end

  // Opcode dispatch and I/O handshakes; mem_we is a one-cycle pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (drdy_in) begin
            case (1'b1)
              operation_in[OP_INC],
              operation_in[OP_DEC]: begin
                mem_we    <= 1'b1;
                mem_addr  <= dp_in;
                mem_wdata <= a_in;
              end
              operation_in[OP_IN]: begin
                ptr      <= dp_in;
                in_ready <= 1'b1;
                state    <= IN_WAIT;
              end
              operation_in[OP_OUT]: begin
                out_data  <= a_in;
                out_valid <= 1'b1;
                state     <= OUT_WAIT;
              end
              default: ;
            endcase
          end
        end
        OUT_WAIT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        IN_WAIT: begin
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= in_data;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_writeback.sv
// Bench for stage_writeback: queued expectations for RAM
// writes and OUT bytes, checked by an independent monitor.
module tb_stage_writeback;
  import stage_writeback_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [OPCODE_MSB:0] operation_in = '0;
  logic [7:0]          a_in = '0;
  logic [15:0]         dp_in = '0;
  logic                drdy_in = 1'b0;
  logic                ack;
  logic                mem_we;
  logic [15:0]         mem_addr;
  logic [7:0]          mem_wdata;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [7:0]          in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                busy;

  stage_writeback #(.D_WIDTH(8), .A_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .operation_in(operation_in), .a_in(a_in),
    .dp_in(dp_in), .drdy_in(drdy_in), .ack(ack),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] oq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write and every OUT handshake must match
  // the oldest queued expectation
  always @(negedge clk) begin
    if (reset && mem_we) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got %0h@%0h expected none",
                 mem_wdata, mem_addr);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", 32'(mem_wdata), 32'(e.d));
      end
    end
    if (reset && out_valid && out_ready) begin
      if (oq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got %0h expected none",
                 out_data);
      end else begin
        chk("out_byte", 32'(out_data), 32'(oq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #13;
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_oval", 32'(out_valid), 0);
    chk("rst_odata", 32'(out_data), 0);
    chk("rst_irdy", 32'(in_ready), 0);
    chk("rst_ack", 32'(ack), 1);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // INC: single write one cycle after acceptance
    operation_in = 4'(1 << OP_INC);
    a_in = 8'h05;
    dp_in = 16'h0010;
    drdy_in = 1'b1;
    wq.push_back('{16'h0010, 8'h05});
    cyc();
    drdy_in = 1'b0;
    chk("inc_we", 32'(mem_we), 1);
    chk("inc_ack", 32'(ack), 1);
    cyc();
    chk("inc_pulse", 32'(mem_we), 0);

    // Back-to-back DEC, no bubbles
    begin
      logic [15:0] da[3];
      logic [7:0]  dd[3];
      da = '{16'h0001, 16'h0002, 16'h0003};
      dd = '{8'hFF, 8'h00, 8'h7F};
      operation_in = 4'(1 << OP_DEC);
      drdy_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
        a_in = dd[i];
        dp_in = da[i];
        wq.push_back('{da[i], dd[i]});
        cyc();
        chk("dec_b2b_we", 32'(mem_we), 1);
        chk("dec_b2b_ack", 32'(ack), 1);
      end
      drdy_in = 1'b0;
      cyc();
      chk("dec_end", 32'(mem_we), 0);
    end

    // Early in_valid in IDLE must not cause a write
    in_valid = 1'b1;
    in_data = 8'h33;
    cyc();
    cyc();
    in_valid = 1'b0;

    // OUT with 4 stall cycles; DEC offered meanwhile
    operation_in = 4'(1 << OP_OUT);
    a_in = 8'h41;
    dp_in = 16'h0020;
    drdy_in = 1'b1;
    oq.push_back(8'h41);
    cyc();
    operation_in = 4'(1 << OP_DEC);
    a_in = 8'h55;
    dp_in = 16'h0099;
    for (int i = 0; i < 5; i++) begin
      chk("out_valid_w", 32'(out_valid), 1);
      chk("out_data_w", 32'(out_data), 32'h41);
      chk("out_ack_w", 32'(ack), 0);
      chk("out_busy_w", 32'(busy), 1);
      if (i == 4) begin
        out_ready = 1'b1;
        drdy_in = 1'b0;
      end
      cyc();
    end
    out_ready = 1'b0;
    chk("out_done_v", 32'(out_valid), 0);
    chk("out_done_ack", 32'(ack), 1);
    cyc();

    // IN at 0x1234, input arrives 3 cycles later
    operation_in = 4'(1 << OP_IN);
    a_in = 8'hEE;
    dp_in = 16'h1234;
    drdy_in = 1'b1;
    cyc();
    drdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("in_rdy_w", 32'(in_ready), 1);
      chk("in_busy_w", 32'(busy), 1);
      cyc();
    end
    in_valid = 1'b1;
    in_data = 8'h7A;
    wq.push_back('{16'h1234, 8'h7A});
    cyc();
    in_valid = 1'b0;
    chk("in_rdy_done", 32'(in_ready), 0);
    chk("in_we", 32'(mem_we), 1);
    chk("in_ack", 32'(ack), 1);
    cyc();
    chk("in_pulse", 32'(mem_we), 0);

    // Priority: INC|OUT acts as INC, DEC|IN acts as DEC
    operation_in = 4'((1 << OP_INC) | (1 << OP_OUT));
    a_in = 8'h09;
    dp_in = 16'h0042;
    drdy_in = 1'b1;
    wq.push_back('{16'h0042, 8'h09});
    cyc();
    chk("pri_inc_oval", 32'(out_valid), 0);
    chk("pri_inc_ack", 32'(ack), 1);
    operation_in = 4'((1 << OP_DEC) | (1 << OP_IN));
    a_in = 8'h0A;
    dp_in = 16'hFFFF;
    wq.push_back('{16'hFFFF, 8'h0A});
    cyc();
    chk("pri_dec_irdy", 32'(in_ready), 0);
    // NOP: consumed silently
    operation_in = '0;
    cyc();
    drdy_in = 1'b0;
    chk("nop_ack", 32'(ack), 1);
    cyc();

    // Async reset during OUT_WAIT drops the byte
    operation_in = 4'(1 << OP_OUT);
    a_in = 8'h5A;
    drdy_in = 1'b1;
    cyc();
    drdy_in = 1'b0;
    chk("rst_pre_oval", 32'(out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_oval", 32'(out_valid), 0);
    chk("arst_irdy", 32'(in_ready), 0);
    chk("arst_we", 32'(mem_we), 0);
    chk("arst_ack", 32'(ack), 1);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    cyc();
    cyc();
    out_ready = 1'b0;
    chk("post_rst_ack", 32'(ack), 1);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_we", 32'(mem_we), 0);

    cyc();
    chk("wq_drained", 32'(wq.size()), 0);
    chk("oq_drained", 32'(oq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
